// File: rtl/pipe_reg_elastic.sv
//------------------------------------------------------------------------------
// Module   : pipe_reg_elastic
// Brief    : Multi-stage elastic pipeline register with ready/valid handshake,
//            bubble collapsing, flush, and programmable reset value.
//            Optional macro PIPE_REG_STALL_CNT_EN adds a 16-bit stall counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_reg_elastic #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
`ifdef PIPE_REG_STALL_CNT_EN
  output logic [15:0]                stall_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int c_OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d [DEPTH];
  logic [DEPTH-1:0] w_rdy;
  logic             w_hole;
  logic [c_OCC_W-1:0] w_occ;

  // A stage can load whenever the sink takes data or any slot at or after it is empty.
  always_comb begin
    w_hole = out_ready;
    w_rdy  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      w_hole   = w_hole | ~w_v[i];
      w_rdy[i] = w_hole;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             r_v;
      logic [WIDTH-1:0] r_d;
      logic             w_up_v;
      logic [WIDTH-1:0] w_up_d;

      if (i == 0) begin : g_head
        assign w_up_v = in_valid;
        assign w_up_d = in_data;
      end else begin : g_body
        assign w_up_v = w_v[i-1];
        assign w_up_d = w_d[i-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v <= 1'b0;
          r_d <= RESET_VAL;
        end else if (flush) begin
          r_v <= 1'b0;
        end else if (w_rdy[i]) begin
          r_v <= w_up_v;
          if (w_up_v) begin
            r_d <= w_up_d;
          end
        end
      end

      assign w_v[i] = r_v;
      assign w_d[i] = r_d;
    end
  endgenerate

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + c_OCC_W'(w_v[i]);
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = w_v[DEPTH-1] & ~flush;
  assign out_data  = w_d[DEPTH-1];
  assign occupancy = w_occ;

`ifdef PIPE_REG_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_v[DEPTH-1] && !out_ready && !flush && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
